ex_flag_stage: RTL and testbench

EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

---
 rtl/ex_flag_stage.sv | 81 ++++++++
 tb/tb_ex_flag_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX/MEM pipeline register plus architectural {Z,V,N} flag register and branch resolve.
// Define FLAG_FWD_EN to evaluate branch_taken on next-state flags instead of the registered flags.
module ex_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flags,
  input  logic [3:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [15:0] ex_store_data,
  input  logic        id_branch,
  input  logic [2:0]  id_ccc,
  output logic        mem_valid,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_store_data,
  output logic [3:0]  mem_rd,
  output logic [2:0]  flags,
  output logic        branch_taken
);
  logic       accept, upd, upd_all, upd_z, z, v, n, cond;
  logic [2:0] flags_nxt, f;
  always_comb begin
    accept    = !stall && !flush;
    upd       = accept && ex_valid && !ex_opcode[3];
    upd_all   = upd && (ex_opcode[2:1] == 2'b00);
    upd_z     = upd && (ex_opcode[2:0] == 3'd2 || ex_opcode[2:0] == 3'd4 ||
                        ex_opcode[2:0] == 3'd5 || ex_opcode[2:0] == 3'd6);
    flags_nxt = upd_all ? alu_flags : upd_z ? {alu_flags[2], flags[1:0]} : flags;
`ifdef FLAG_FWD_EN
    f = flags_nxt;
`else
    f = flags;
`endif
    {z, v, n} = f;
    cond = id_ccc == 3'd0 ? !z :
           id_ccc == 3'd1 ? z :
           id_ccc == 3'd2 ? !z && !n :
           id_ccc == 3'd3 ? n :
           id_ccc == 3'd4 ? z || !n :
           id_ccc == 3'd5 ? n || z :
           id_ccc == 3'd6 ? v : 1'b1;
    branch_taken = id_branch && cond;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      flags          <= '0;
    end else begin
      if (flush) begin
        mem_valid    <= 1'b0;
        mem_regwrite <= 1'b0;
        mem_memread  <= 1'b0;
        mem_memwrite <= 1'b0;
      end else if (!stall) begin
        mem_valid      <= ex_valid;
        mem_regwrite   <= ex_regwrite;
        mem_memread    <= ex_memread;
        mem_memwrite   <= ex_memwrite;
        mem_alu_result <= alu_out;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
      end
      flags <= flags_nxt;
    end
  end
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: directed and random stimulus against a behavioural model of ex_flag_stage.
module tb_ex_flag_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
  logic [3:0]  ex_opcode = '0, ex_rd = '0;
  logic [15:0] alu_out = '0, ex_store_data = '0;
  logic [2:0]  alu_flags = '0, id_ccc = '0;
  logic        ex_regwrite = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, id_branch = 1'b0;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, branch_taken;
  logic [15:0] mem_alu_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic [2:0]  flags;
  int n_chk = 0, n_fail = 0;
  logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0;
  logic [15:0] m_res = 0, m_sd = 0;
  logic [3:0]  m_rd = 0;
  logic [2:0]  m_flags = 0;
  localparam logic [3:0] ADD = 0, SUB = 1, XOR = 2, RED = 3, SLL = 4, SRA = 5, ROR = 6, PADDSB = 7;
  ex_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .alu_out(alu_out), .alu_flags(alu_flags), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_store_data(ex_store_data), .id_branch(id_branch), .id_ccc(id_ccc),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .flags(flags),
    .branch_taken(branch_taken)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] model_next(input logic [2:0] cur);
    logic [2:0] r = cur;
    if (!stall && !flush && ex_valid && !ex_opcode[3])
      case ({1'b0, ex_opcode[2:0]})
        ADD, SUB:           r = alu_flags;
        XOR, SLL, SRA, ROR: r[2] = alu_flags[2];
        default:            ;
      endcase
    return r;
  endfunction
  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic z = f[2], v = f[1], n = f[0];
    case (c)
      3'd0: return z == 0;
      3'd1: return z == 1;
      3'd2: return z == 0 && n == 0;
      3'd3: return n == 1;
      3'd4: return z == 1 || (z == 0 && n == 0);
      3'd5: return n == 1 || z == 1;
      3'd6: return v == 1;
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic model_bt();
`ifdef FLAG_FWD_EN
    return id_branch && cond_ok(id_ccc, model_next(m_flags));
`else
    return id_branch && cond_ok(id_ccc, m_flags);
`endif
  endfunction
  task automatic check_outs(input string tag);
    check({tag, ".valid"}, mem_valid, m_valid);
    check({tag, ".ctl"}, {mem_regwrite, mem_memread, mem_memwrite}, {m_rw, m_mr, m_mw});
    check({tag, ".res"}, mem_alu_result, m_res);
    check({tag, ".sd"}, mem_store_data, m_sd);
    check({tag, ".rd"}, mem_rd, m_rd);
    check({tag, ".flags"}, flags, m_flags);
  endtask
  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] af,
                       input logic st, input logic fl);
    ex_valid = v; ex_opcode = op; alu_flags = af; stall = st; flush = fl;
    alu_out = 16'($urandom); ex_store_data = 16'($urandom); ex_rd = 4'($urandom);
    {ex_regwrite, ex_memread, ex_memwrite} = 3'($urandom);
    id_branch = 1'($urandom); id_ccc = 3'($urandom);
  endtask
  // One clock: branch check before the edge, model update at the edge, register check after.
  task automatic cyc(input string tag);
    #1 check({tag, ".bt"}, branch_taken, model_bt());
    @(posedge clk);
    m_flags = model_next(m_flags);
    if (flush) {m_valid, m_rw, m_mr, m_mw} = 4'b0;
    else if (!stall) begin
      {m_valid, m_rw, m_mr, m_mw} = {ex_valid, ex_regwrite, ex_memread, ex_memwrite};
      m_res = alu_out; m_sd = ex_store_data; m_rd = ex_rd;
    end
    #1 check_outs(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_outs("reset");
    id_branch = 1; id_ccc = 3'd0;
    #1 check("reset.bt000", branch_taken, 1'b1);
    id_ccc = 3'd1;
    #1 check("reset.bt001", branch_taken, 1'b0);
    rst_n = 1;
    drive(1, ADD, 3'b110, 0, 0); cyc("add");
    check("add.flags110", flags, 3'b110);
    check("add.valid", mem_valid, 1'b1);
    drive(1, ADD, 3'b011, 0, 0); cyc("set011");
    drive(1, XOR, 3'b100, 0, 0); cyc("xor");
    check("xor.flags111", flags, 3'b111);
    drive(1, RED, 3'b000, 0, 0); cyc("red");
    check("red.flags111", flags, 3'b111);
    for (int i = 0; i < 3; i++) begin
      drive(1, SUB, 3'b001, 1, 0); cyc("stall");
    end
    check("stall.flags", flags, 3'b111);
    stall = 0; cyc("unstall");
    check("unstall.flags001", flags, 3'b001);
    drive(1, ADD, 3'b110, 1, 1); cyc("stallflush");
    check("stallflush.ctl", {mem_valid, mem_regwrite, mem_memread, mem_memwrite}, 4'b0);
    check("stallflush.flags", flags, 3'b001);
    drive(1, ADD, 3'b000, 0, 0); cyc("clear");
    drive(1, ADD, 3'b100, 0, 0); id_branch = 1; id_ccc = 3'd1;
`ifdef FLAG_FWD_EN
    #1 check("fwd.bt_same", branch_taken, 1'b1);
`else
    #1 check("nofwd.bt_same", branch_taken, 1'b0);
`endif
    cyc("fwd");
    ex_valid = 0;
    #1 check("fwd.bt_next", branch_taken, 1'b1);
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 4'($urandom), 3'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      cyc("rand");
    end
    drive(1, SUB, 3'b111, 0, 0); cyc("pre_rst");
    drive(0, ADD, 3'b000, 0, 0); id_branch = 1; id_ccc = 3'd7;
    #2 rst_n = 0;
    {m_valid, m_rw, m_mr, m_mw, m_res, m_sd, m_rd, m_flags} = '0;
    #1 check_outs("async_rst");
    check("async_rst.bt111", branch_taken, 1'b1);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3) == 0, 1'b0);
      cyc("post_rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
